// File: rtl/branch_resolve_unit.sv
// Branch resolution: in-order prediction FIFO checked against execute results,
// with flush/recover sequencing, predictor training strobes and statistics.
module branch_resolve_unit #(
    parameter int PC_WIDTH       = 32,
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic                pred_taken,
    input  logic [PC_WIDTH-1:0] pred_pc,
    output logic                pred_ready,
    input  logic                res_valid,
    input  logic                res_taken,
    input  logic [PC_WIDTH-1:0] res_next_pc,
    output logic                upd_valid,
    output logic                upd_taken,
    output logic                flush,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic [15:0]         branch_count,
    output logic [15:0]         mispredict_count,
    output logic                err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_FLUSH,
        ST_RECOVER
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [RW-1:0]         r_rcnt;
    logic                  r_upd_valid;
    logic                  r_upd_taken;
    logic                  r_flush;
    logic [PC_WIDTH-1:0]   r_redirect;
    logic [15:0]           r_bcnt;
    logic [15:0]           r_mcnt;
    logic                  r_err;

    logic                  r_mem_taken [DEPTH];
    logic [PC_WIDTH-1:0]   r_mem_pc    [DEPTH];

    logic                  w_normal;
    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_mis;
    logic                  w_empty_res;

    assign w_normal    = (r_state == ST_NORMAL);
    assign w_ready     = w_normal && (r_count < CW'(DEPTH));
    assign w_push      = pred_valid && w_ready;
    assign w_pop       = res_valid && w_normal && (r_count != '0);
    assign w_empty_res = res_valid && w_normal && (r_count == '0);
    assign w_mis       = w_pop && ((res_taken != r_mem_taken[r_rptr]) ||
                                   (res_next_pc != r_mem_pc[r_rptr]));

    // Storage has no reset; occupancy and pointers define what is live.
    always_ff @(posedge clk) begin
        if (w_push && !w_mis) begin
            r_mem_taken[r_wptr] <= pred_taken;
            r_mem_pc[r_wptr]    <= pred_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_NORMAL;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_rcnt      <= '0;
            r_upd_valid <= 1'b0;
            r_upd_taken <= 1'b0;
            r_flush     <= 1'b0;
            r_redirect  <= '0;
            r_bcnt      <= '0;
            r_mcnt      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_upd_valid <= w_pop;
            r_upd_taken <= w_pop && res_taken;
            r_flush     <= 1'b0;
            if (w_empty_res)
                r_err <= 1'b1;
            if (w_pop && r_bcnt != 16'hFFFF)
                r_bcnt <= r_bcnt + 16'd1;
            if (w_mis && r_mcnt != 16'hFFFF)
                r_mcnt <= r_mcnt + 16'd1;
            case (r_state)
                ST_NORMAL: begin
                    if (w_mis) begin
                        r_state    <= ST_FLUSH;
                        r_flush    <= 1'b1;
                        r_redirect <= res_next_pc;
                        r_count    <= '0;
                        r_wptr     <= '0;
                        r_rptr     <= '0;
                    end else begin
                        if (w_push)
                            r_wptr <= r_wptr + 1'b1;
                        if (w_pop)
                            r_rptr <= r_rptr + 1'b1;
                        if (w_push && !w_pop)
                            r_count <= r_count + 1'b1;
                        else if (!w_push && w_pop)
                            r_count <= r_count - 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_rcnt  <= '0;
                    r_state <= (RECOVER_CYCLES == 0) ? ST_NORMAL : ST_RECOVER;
                end
                ST_RECOVER: begin
                    if (r_rcnt == RW'(RECOVER_CYCLES - 1))
                        r_state <= ST_NORMAL;
                    else
                        r_rcnt <= r_rcnt + 1'b1;
                end
                default: r_state <= ST_NORMAL;
            endcase
        end
    end

    assign pred_ready       = w_ready;
    assign upd_valid        = r_upd_valid;
    assign upd_taken        = r_upd_taken;
    assign flush            = r_flush;
    assign redirect_pc      = r_redirect;
    assign branch_count     = r_bcnt;
    assign mispredict_count = r_mcnt;
    assign err              = r_err;

endmodule
